// File: rtl/cxs_pkg.sv
// Shared definitions for the CXS receive path.
// Holds header bit offsets, the fixed config-field values a legal header
// must carry, the receiver FSM state type, the per-flit status code type
// and the layout of one buffered flit.
package cxs_pkg;

    // Header bit offsets (header = flit[511:256]).
    localparam int HDR_DP   = 255;  // data parity: XOR of payload
    localparam int HDR_CP   = 254;  // control parity: XOR of header[253:0]
    localparam int PRCL_HI  = 51;
    localparam int PRCL_LO  = 49;
    localparam int MPPF_HI  = 48;
    localparam int MPPF_LO  = 47;
    localparam int FW_HI    = 46;
    localparam int FW_LO    = 45;
    localparam int LAST_BIT = 44;
    localparam int CNTL_HI  = 13;
    localparam int CNTL_LO  = 0;

    // Only configuration this receiver accepts.
    localparam logic [1:0] MAX_PKT_PERFLIT = 2'b01;
    localparam logic [1:0] DATA_FLITWIDTH  = 2'b01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } rx_state_e;

    typedef enum logic [1:0] {
        STS_IDLE    = 2'b00,
        STS_GOOD    = 2'b01,
        STS_HDR_ERR = 2'b10,
        STS_DROP    = 2'b11
    } pkt_sts_e;

    // One buffered flit: only the fields forwarded to the consumer.
    typedef struct packed {
        logic [2:0]   prcltype;
        logic         last;
        logic [13:0]  cntl;
        logic [255:0] payload;
    } fifo_word_t;

    localparam int FIFO_W = $bits(fifo_word_t);

endpackage

// File: rtl/cxs_rx_fifo.sv
// Synchronous FIFO holding checked flits.
// Ports: clk/rst_n (sync active-low), push + wr_data, pop, rd_data (head,
// combinational), full, empty, count (occupancy 0..DEPTH).
// Push while full is legal only together with a pop in the same cycle.
module cxs_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 274
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wr_data,
    input  logic                     pop,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/cxs_rx_512to256.sv
// CXS receive stage: checks 512-bit flits from the transmitter, buffers the
// good ones and re-emits them as a 256-bit stream gated by consumer credits.
// Ports: cxs_clk, cxs_rst_n (sync active-low), rx_en, tx_pkt_vld/tx_pkt_data
// (flit in, no backpressure), rx_ready (to transmitter), rxcxs_crdgnt (credit
// in), rxcxs_crdrtn (credit return while draining), rxcxs_valid/data/cntl/
// last/prcltype (stream out), pkt_rcv_sts (per-flit result), drop_cnt.
// Handshake: the transmitter never stalls; rx_ready is advisory. One output
// flit consumes one credit; rxcxs_valid is a single-cycle pulse per flit.
module cxs_rx_512to256
    import cxs_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_CREDIT = 8,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 cxs_clk,
    input  logic                 cxs_rst_n,
    input  logic                 rx_en,
    input  logic                 tx_pkt_vld,
    input  logic [511:0]         tx_pkt_data,
    output logic                 rx_ready,
    input  logic                 rxcxs_crdgnt,
    output logic                 rxcxs_crdrtn,
    output logic                 rxcxs_valid,
    output logic [255:0]         rxcxs_data,
    output logic [13:0]          rxcxs_cntl,
    output logic                 rxcxs_last,
    output logic [2:0]           rxcxs_prcltype,
    output logic [1:0]           pkt_rcv_sts,
    output logic [ERR_CNT_W-1:0] drop_cnt
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CRD_W = $clog2(MAX_CREDIT + 1);

    rx_state_e            state_q, state_d;
    logic                 s1_vld_q, s1_vld_d;
    logic [511:0]         s1_data_q, s1_data_d;
    pkt_sts_e             sts_q, sts_d;
    logic [ERR_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CRD_W-1:0]     crd_cnt_q, crd_cnt_d;
    logic                 rx_ready_q, rx_ready_d;
    logic                 crdrtn_q, crdrtn_d;
    logic                 valid_q, valid_d;
    fifo_word_t           out_q, out_d;

    logic [255:0]         hdr, pay;
    logic                 perr, herr, room, push, pop, drop, crd_inc;
    logic                 fifo_full, fifo_empty;
    logic [CNT_W-1:0]     fifo_cnt;
    fifo_word_t           wr_word, rd_word;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge cxs_clk) begin
        if (!cxs_rst_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rx_en) state_d = ACTIVE;
            ACTIVE:  if (!rx_en) state_d = DRAIN;
            DRAIN: begin
                if (rx_en)                                state_d = ACTIVE;
                else if (fifo_empty && crd_cnt_q == '0)   state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Credit return waits for an empty FIFO and an empty check stage, so a
    // flit still in flight when rx_en falls keeps a credit for its own pop.
    always_comb begin
        rx_ready_d = (state_q == ACTIVE) && (fifo_cnt < CNT_W'(FIFO_DEPTH - 1));
        crdrtn_d   = (state_q == DRAIN) && fifo_empty && !s1_vld_q && (crd_cnt_q != '0);
    end

    // ---------------- Stage 1: check register ----------------
    assign hdr = s1_data_q[511:256];
    assign pay = s1_data_q[255:0];

    always_comb begin
        s1_vld_d  = tx_pkt_vld;
        s1_data_d = tx_pkt_data;
        perr = (hdr[HDR_DP] != ^pay) || (hdr[HDR_CP] != ^hdr[HDR_CP-1:0]);
        herr = (|hdr[253:52]) || (|hdr[43:14])
            || (hdr[MPPF_HI:MPPF_LO] != MAX_PKT_PERFLIT)
            || (hdr[FW_HI:FW_LO] != DATA_FLITWIDTH);
    end

    // ---------------- Stage 2: FIFO write, status, drops ----------------
    always_comb begin
        wr_word.prcltype = hdr[PRCL_HI:PRCL_LO];
        wr_word.last     = hdr[LAST_BIT];
        wr_word.cntl     = hdr[CNTL_HI:CNTL_LO];
        wr_word.payload  = pay;

        pop  = !fifo_empty && (crd_cnt_q != '0) && (state_q != IDLE);
        // A full FIFO still has room when the head leaves this same cycle.
        room = !fifo_full || pop;
        push = s1_vld_q && !perr && !herr && (state_q != IDLE) && room;
        drop = s1_vld_q && !push;

        sts_d = STS_IDLE;
        if (s1_vld_q) begin
            if (perr)                          sts_d = STS_DROP;
            else if (herr)                     sts_d = STS_HDR_ERR;
            else if (!room || state_q == IDLE) sts_d = STS_DROP;
            else                               sts_d = STS_GOOD;
        end

        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != {ERR_CNT_W{1'b1}})
            drop_cnt_d = drop_cnt_q + ERR_CNT_W'(1);
    end

    cxs_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FIFO_W)
    ) u_fifo (
        .clk     (cxs_clk),
        .rst_n   (cxs_rst_n),
        .push    (push),
        .wr_data (wr_word),
        .pop     (pop),
        .rd_data (rd_word),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_cnt)
    );

    // ---------------- Credits and output stage ----------------
    // A grant at the cap is still usable when a credit leaves the same cycle.
    always_comb begin
        crd_inc   = rxcxs_crdgnt && ((crd_cnt_q < CRD_W'(MAX_CREDIT)) || pop || crdrtn_d);
        crd_cnt_d = crd_cnt_q + CRD_W'(crd_inc) - CRD_W'(pop || crdrtn_d);
        valid_d   = pop;
        out_d     = pop ? rd_word : out_q;
    end

    always_ff @(posedge cxs_clk) begin
        if (!cxs_rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_data_q  <= '0;
            sts_q      <= STS_IDLE;
            drop_cnt_q <= '0;
            crd_cnt_q  <= '0;
            rx_ready_q <= 1'b0;
            crdrtn_q   <= 1'b0;
            valid_q    <= 1'b0;
            out_q      <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_data_q  <= s1_data_d;
            sts_q      <= sts_d;
            drop_cnt_q <= drop_cnt_d;
            crd_cnt_q  <= crd_cnt_d;
            rx_ready_q <= rx_ready_d;
            crdrtn_q   <= crdrtn_d;
            valid_q    <= valid_d;
            out_q      <= out_d;
        end
    end

    assign rx_ready       = rx_ready_q;
    assign rxcxs_crdrtn   = crdrtn_q;
    assign rxcxs_valid    = valid_q;
    assign rxcxs_data     = out_q.payload;
    assign rxcxs_cntl     = out_q.cntl;
    assign rxcxs_last     = out_q.last;
    assign rxcxs_prcltype = out_q.prcltype;
    assign pkt_rcv_sts    = sts_q;
    assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_cxs_rx_512to256.sv
module tb_cxs_rx_512to256;
    import cxs_pkg::*;

    logic         cxs_clk = 1'b0;
    logic         cxs_rst_n;
    logic         rx_en;
    logic         tx_pkt_vld;
    logic [511:0] tx_pkt_data;
    logic         rx_ready;
    logic         rxcxs_crdgnt;
    logic         rxcxs_crdrtn;
    logic         rxcxs_valid;
    logic [255:0] rxcxs_data;
    logic [13:0]  rxcxs_cntl;
    logic         rxcxs_last;
    logic [2:0]   rxcxs_prcltype;
    logic [1:0]   pkt_rcv_sts;
    logic [7:0]   drop_cnt;

    int n_checks   = 0;
    int n_errors   = 0;
    int valid_cnt  = 0;
    int crdrtn_cnt = 0;
    logic [273:0] exp_q[$];

    // ---------------- clock ----------------
    always #5 cxs_clk = ~cxs_clk;

    cxs_rx_512to256 dut (
        .cxs_clk        (cxs_clk),
        .cxs_rst_n      (cxs_rst_n),
        .rx_en          (rx_en),
        .tx_pkt_vld     (tx_pkt_vld),
        .tx_pkt_data    (tx_pkt_data),
        .rx_ready       (rx_ready),
        .rxcxs_crdgnt   (rxcxs_crdgnt),
        .rxcxs_crdrtn   (rxcxs_crdrtn),
        .rxcxs_valid    (rxcxs_valid),
        .rxcxs_data     (rxcxs_data),
        .rxcxs_cntl     (rxcxs_cntl),
        .rxcxs_last     (rxcxs_last),
        .rxcxs_prcltype (rxcxs_prcltype),
        .pkt_rcv_sts    (pkt_rcv_sts),
        .drop_cnt       (drop_cnt)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [273:0] obs, input logic [273:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- helpers ----------------
    function automatic logic [511:0] make_flit(input logic [13:0] cntl, input logic last,
                                               input logic [2:0] prcl, input logic [255:0] pay);
        logic [255:0] h;
        h        = '0;
        h[13:0]  = cntl;
        h[44]    = last;
        h[46:45] = 2'b01;
        h[48:47] = 2'b01;
        h[51:49] = prcl;
        h[254]   = ^h[253:0];
        h[255]   = ^pay;
        return {h, pay};
    endfunction

    function automatic logic [273:0] word_of(input logic [511:0] f);
        return {f[307:305], f[300], f[269:256], f[255:0]};
    endfunction

    task automatic tick();
        @(posedge cxs_clk);
        #1;
    endtask

    task automatic drive_flit(input logic [511:0] f, input bit good);
        tx_pkt_vld  = 1'b1;
        tx_pkt_data = f;
        if (good) exp_q.push_back(word_of(f));
        tick();
        tx_pkt_vld  = 1'b0;
    endtask

    task automatic grant(input int n);
        rxcxs_crdgnt = 1'b1;
        repeat (n) tick();
        rxcxs_crdgnt = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rx_ready"}, 274'(rx_ready), 274'(0));
        check({tag, "_crdrtn"},   274'(rxcxs_crdrtn), 274'(0));
        check({tag, "_valid"},    274'(rxcxs_valid), 274'(0));
        check({tag, "_fields"},   {rxcxs_prcltype, rxcxs_last, rxcxs_cntl, rxcxs_data}, 274'(0));
        check({tag, "_sts"},      274'(pkt_rcv_sts), 274'(0));
        check({tag, "_drop_cnt"}, 274'(drop_cnt), 274'(0));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge cxs_clk) begin
        if (rxcxs_crdrtn) crdrtn_cnt++;
        if (rxcxs_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) check("unexpected_valid", 274'(1), 274'(0));
            else check("rx_word", {rxcxs_prcltype, rxcxs_last, rxcxs_cntl, rxcxs_data},
                       exp_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [511:0] f;
        logic [255:0] p;
        int v0, c0;
        bit rdy3, rdy4, ready_low;

        cxs_rst_n = 1'b0; rx_en = 1'b0; tx_pkt_vld = 1'b0;
        tx_pkt_data = '0; rxcxs_crdgnt = 1'b0;
        tick(); tick();
        check_outputs_zero("reset");

        // Enable: rx_ready rises on the second edge.
        cxs_rst_n = 1'b1; rx_en = 1'b1;
        tick();
        check("ready_edge1", 274'(rx_ready), 274'(0));
        tick();
        check("ready_edge2", 274'(rx_ready), 274'(1));

        // Good flit with 2 credits.
        grant(2);
        p = {8{32'hC0DE_0001}};
        drive_flit(make_flit(14'h1A5, 1'b1, 3'b010, p), 1'b1);      // E0
        check("lat_e0_valid", 274'(rxcxs_valid), 274'(0));
        tick();                                                    // E1
        check("good_sts", 274'(pkt_rcv_sts), 274'(2'b01));
        check("lat_e1_valid", 274'(rxcxs_valid), 274'(0));
        tick();                                                    // E2
        check("lat_e2_valid", 274'(rxcxs_valid), 274'(1));
        check("good_cntl", 274'(rxcxs_cntl), 274'(14'h1A5));
        check("good_last", 274'(rxcxs_last), 274'(1));
        check("good_prcl", 274'(rxcxs_prcltype), 274'(3'b010));
        check("good_data", 274'(rxcxs_data), 274'(p));
        check("good_drop_cnt", 274'(drop_cnt), 274'(0));
        tick();
        check("valid_one_cycle", 274'(rxcxs_valid), 274'(0));

        // Reserved header bit set, parity kept consistent.
        f = make_flit(14'h0011, 1'b0, 3'b001, {8{32'h1234_5678}});
        f[356] = ~f[356];
        f[510] = ^f[509:256];
        drive_flit(f, 1'b0);
        tick();
        check("hdr_err_sts", 274'(pkt_rcv_sts), 274'(2'b10));
        check("hdr_err_drop", 274'(drop_cnt), 274'(1));
        tick();

        // Payload bit flipped, parity left stale.
        f = make_flit(14'h0022, 1'b0, 3'b001, {8{32'h8765_4321}});
        f[0] = ~f[0];
        drive_flit(f, 1'b0);
        tick();
        check("perr_sts", 274'(pkt_rcv_sts), 274'(2'b11));
        check("perr_drop", 274'(drop_cnt), 274'(2));
        tick();

        // Spend the remaining credit so the next burst sees none.
        drive_flit(make_flit(14'h0033, 1'b0, 3'b100, {8{32'hAAAA_5555}}), 1'b1);
        tick(); tick(); tick();

        // Four good flits then a fifth into a full FIFO, no credits.
        rdy3 = 1'b0; rdy4 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive_flit(make_flit(14'(k + 1), k[0], 3'(k), {8{32'(32'hF000_0000 + k)}}), k < 4);
            if (k == 3) rdy3 = rx_ready;
            if (k == 4) rdy4 = rx_ready;
        end
        check("ready_cnt2", 274'(rdy3), 274'(1));
        check("ready_cnt3", 274'(rdy4), 274'(0));
        tick();
        check("overflow_sts", 274'(pkt_rcv_sts), 274'(2'b11));
        check("overflow_drop", 274'(drop_cnt), 274'(3));

        v0 = valid_cnt;
        grant(8);
        repeat (4) tick();
        check("burst_pulses", 274'(valid_cnt - v0), 274'(4));
        check("burst_queue_empty", 274'(exp_q.size()), 274'(0));

        // Saturate credits (4 held + 10 grants), then grant during a pop.
        rxcxs_crdgnt = 1'b1;
        repeat (10) tick();
        v0 = valid_cnt;
        drive_flit(make_flit(14'h2BC, 1'b1, 3'b111, {8{32'h0BAD_F00D}}), 1'b1);
        tick(); tick();
        rxcxs_crdgnt = 1'b0;
        tick();
        check("sat_pop_pulse", 274'(valid_cnt - v0), 274'(1));
        c0 = crdrtn_cnt;
        rx_en = 1'b0;
        repeat (14) tick();
        check("sat_crdrtn_cnt", 274'(crdrtn_cnt - c0), 274'(8));
        check("sat_state_idle", 274'(dut.state_q), 274'(IDLE));

        // Drain with 3 credits and one in-flight flit.
        rx_en = 1'b1;
        tick(); tick();
        check("reenable_ready", 274'(rx_ready), 274'(1));
        grant(3);
        v0 = valid_cnt; c0 = crdrtn_cnt;
        rx_en = 1'b0;
        drive_flit(make_flit(14'h3FF, 1'b0, 3'b011, {8{32'h5EED_1234}}), 1'b1);
        ready_low = 1'b1;
        repeat (8) begin
            tick();
            if (rx_ready) ready_low = 1'b0;
        end
        check("drain_pulses", 274'(valid_cnt - v0), 274'(1));
        check("drain_crdrtn", 274'(crdrtn_cnt - c0), 274'(2));
        check("drain_ready_low", 274'(ready_low), 274'(1));
        check("drain_state_idle", 274'(dut.state_q), 274'(IDLE));

        // Reset while two flits are queued: they must vanish.
        rx_en = 1'b1;
        tick(); tick();
        drive_flit(make_flit(14'h101, 1'b0, 3'b000, {8{32'h1111_1111}}), 1'b0);
        drive_flit(make_flit(14'h202, 1'b1, 3'b000, {8{32'h2222_2222}}), 1'b0);
        tick();
        cxs_rst_n = 1'b0;
        tick();
        check_outputs_zero("midreset");
        cxs_rst_n = 1'b1;
        v0 = valid_cnt;
        grant(4);
        repeat (6) tick();
        check("post_reset_no_valid", 274'(valid_cnt - v0), 274'(0));
        check("final_queue_empty", 274'(exp_q.size()), 274'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
